// File: rtl/ex_operand_stage.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : ex_operand_stage
// Description : ID/EX register feeding the ALU, with MEM/WB operand
//               forwarding and load-use bubble insertion under EX_FWD_EN.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module ex_operand_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_rs1_data,
   input  logic [DATA_WIDTH-1:0]     in_rs2_data,
   input  logic [DATA_WIDTH-1:0]     in_imm,
   input  logic [DATA_WIDTH-1:0]     in_pc,
   input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
   input  logic                      in_alu_src,
   input  logic [2:0]                in_alu_ctrl,
   input  logic                      in_reg_write,
   input  logic                      in_mem_read,
   input  logic                      in_branch,
   input  logic                      flush,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                      mem_reg_write,
   input  logic                      mem_is_load,
   input  logic [DATA_WIDTH-1:0]     mem_result,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
   input  logic                      wb_reg_write,
   input  logic [DATA_WIDTH-1:0]     wb_result,
   output logic [DATA_WIDTH-1:0]     ALUop1,
   output logic [DATA_WIDTH-1:0]     ALUop2,
   output logic [2:0]                ALUctrl,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_rs2_fwd,
   output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
   output logic [DATA_WIDTH-1:0]     out_pc,
   output logic                      out_reg_write,
   output logic                      out_mem_read,
   output logic                      out_branch,
   output logic [15:0]               bubble_count
);

   localparam logic [REG_ADDR_WIDTH-1:0] C_X0       = '0;
   localparam logic [15:0]               C_BUB_MAX  = 16'hFFFF;

   logic                      r_valid;
   logic [DATA_WIDTH-1:0]     r_rs1_data;
   logic [DATA_WIDTH-1:0]     r_rs2_data;
   logic [DATA_WIDTH-1:0]     r_imm;
   logic [DATA_WIDTH-1:0]     r_pc;
   logic [REG_ADDR_WIDTH-1:0] r_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] r_rs2_addr;
   logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
   logic                      r_alu_src;
   logic [2:0]                r_alu_ctrl;
   logic                      r_reg_write;
   logic                      r_mem_read;
   logic                      r_branch;

   logic [DATA_WIDTH-1:0]     w_fwd_rs1;
   logic [DATA_WIDTH-1:0]     w_fwd_rs2;
   logic                      w_load_use;
   logic                      w_out_valid;
   logic                      w_fire;
   logic                      w_in_ready;
   logic                      w_capture;

`ifdef EX_FWD_EN
   logic [15:0]               r_bubble_cnt;

   // Forwarding only applies to a live entry so idle outputs stay put.
   always_comb begin
      w_fwd_rs1 = r_rs1_data;
      if (r_valid && mem_reg_write && (mem_rd_addr != C_X0) && (mem_rd_addr == r_rs1_addr))
         w_fwd_rs1 = mem_result;
      else if (r_valid && wb_reg_write && (wb_rd_addr != C_X0) && (wb_rd_addr == r_rs1_addr))
         w_fwd_rs1 = wb_result;
   end

   always_comb begin
      w_fwd_rs2 = r_rs2_data;
      if (r_valid && mem_reg_write && (mem_rd_addr != C_X0) && (mem_rd_addr == r_rs2_addr))
         w_fwd_rs2 = mem_result;
      else if (r_valid && wb_reg_write && (wb_rd_addr != C_X0) && (wb_rd_addr == r_rs2_addr))
         w_fwd_rs2 = wb_result;
   end

   assign w_load_use = r_valid && mem_is_load && mem_reg_write && (mem_rd_addr != C_X0) &&
                       ((mem_rd_addr == r_rs1_addr) ||
                        ((mem_rd_addr == r_rs2_addr) && !r_alu_src));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_bubble_cnt <= '0;
      else if (w_load_use && (r_bubble_cnt != C_BUB_MAX))
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
   end

   assign bubble_count = r_bubble_cnt;
`else
   logic w_unused_hazard_inputs;

   assign w_fwd_rs1    = r_rs1_data;
   assign w_fwd_rs2    = r_rs2_data;
   assign w_load_use   = 1'b0;
   assign bubble_count = '0;
   assign w_unused_hazard_inputs = ^{mem_rd_addr, mem_reg_write, mem_is_load, mem_result,
                                     wb_rd_addr, wb_reg_write, wb_result,
                                     r_rs1_addr, r_rs2_addr};
`endif

   assign w_out_valid = r_valid && !w_load_use;
   assign w_fire      = w_out_valid && out_ready;
   assign w_in_ready  = !r_valid || w_fire;
   assign w_capture   = in_valid && w_in_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_pc        <= '0;
         r_rs1_addr  <= '0;
         r_rs2_addr  <= '0;
         r_rd_addr   <= '0;
         r_alu_src   <= 1'b0;
         r_alu_ctrl  <= 3'b000;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_branch    <= 1'b0;
      end else begin
         if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_branch    <= 1'b0;
         end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_rs1_data  <= in_rs1_data;
            r_rs2_data  <= in_rs2_data;
            r_imm       <= in_imm;
            r_pc        <= in_pc;
            r_rs1_addr  <= in_rs1_addr;
            r_rs2_addr  <= in_rs2_addr;
            r_rd_addr   <= in_rd_addr;
            r_alu_src   <= in_alu_src;
            r_alu_ctrl  <= in_alu_ctrl;
            r_reg_write <= in_reg_write;
            r_mem_read  <= in_mem_read;
            r_branch    <= in_branch;
         end else if (w_fire) begin
            r_valid     <= 1'b0;
         end
         // Freeze the forwarded operands as the entry retires so the
         // ALU inputs keep their last values while the slot is empty.
         if (r_valid && !w_capture && (flush || w_fire)) begin
            r_rs1_data  <= w_fwd_rs1;
            r_rs2_data  <= w_fwd_rs2;
         end
      end
   end

   assign in_ready      = w_in_ready;
   assign out_valid     = w_out_valid;
   assign ALUop1        = w_fwd_rs1;
   assign ALUop2        = r_alu_src ? r_imm : w_fwd_rs2;
   assign out_rs2_fwd   = w_fwd_rs2;
   assign ALUctrl       = r_alu_ctrl;
   assign out_rd_addr   = r_rd_addr;
   assign out_pc        = r_pc;
   assign out_reg_write = r_reg_write;
   assign out_mem_read  = r_mem_read;
   assign out_branch    = r_branch;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_ex_operand_stage
// Description : Random plus directed bench for ex_operand_stage against a
//               transaction-level reference model (honours EX_FWD_EN).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_ex_operand_stage;

`ifdef EX_FWD_EN
   localparam bit C_FWD = 1'b1;
`else
   localparam bit C_FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic        in_alu_src;
   logic [2:0]  in_alu_ctrl;
   logic        in_reg_write, in_mem_read, in_branch, flush;
   logic [4:0]  mem_rd_addr, wb_rd_addr;
   logic        mem_reg_write, mem_is_load, wb_reg_write;
   logic [31:0] mem_result, wb_result;
   logic [31:0] ALUop1, ALUop2, out_rs2_fwd, out_pc;
   logic [2:0]  ALUctrl;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd_addr;
   logic        out_reg_write, out_mem_read, out_branch;
   logic [15:0] bubble_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] rs1, rs2, imm, pc;
      logic [4:0]  a1, a2, rd;
      logic        src;
      logic [2:0]  ctrl;
      logic        rw, mr, br;
   } inst_t;

   inst_t m_inst;
   bit    m_valid;
   int    m_bubbles;

   always #5 clk = ~clk;

   ex_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_pc(in_pc),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
      .in_alu_src(in_alu_src), .in_alu_ctrl(in_alu_ctrl),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_branch(in_branch),
      .flush(flush),
      .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
      .mem_is_load(mem_is_load), .mem_result(mem_result),
      .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs2_fwd(out_rs2_fwd), .out_rd_addr(out_rd_addr), .out_pc(out_pc),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_branch(out_branch),
      .bubble_count(bubble_count)
   );

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Architectural value of a source register as seen by the ALU.
   function automatic logic [31:0] model_src(input logic [4:0] a, input logic [31:0] latched);
      if (C_FWD && mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == a) return mem_result;
      if (C_FWD && wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == a) return wb_result;
      return latched;
   endfunction

   function automatic bit model_load_use();
      if (!C_FWD || !m_valid || !mem_is_load || !mem_reg_write || mem_rd_addr == 5'd0) return 1'b0;
      return (mem_rd_addr == m_inst.a1) || (mem_rd_addr == m_inst.a2 && !m_inst.src);
   endfunction

   task automatic model_reset();
      m_valid   = 1'b0;
      m_bubbles = 0;
      m_inst    = '{default: '0};
   endtask

   // Called with inputs already driven; checks, crosses one edge, returns at negedge.
   task automatic cycle();
      bit lu, ov, ir;
      logic [31:0] e2;
      #1;
      lu = model_load_use();
      ov = m_valid && !lu;
      ir = !m_valid || (ov && out_ready);
      check_value("out_valid", 64'(out_valid), 64'(ov));
      check_value("in_ready", 64'(in_ready), 64'(ir));
      check_value("bubble_count", 64'(bubble_count), 64'(m_bubbles));
      if (m_valid) begin
         e2 = model_src(m_inst.a2, m_inst.rs2);
         check_value("ALUop1", 64'(ALUop1), 64'(model_src(m_inst.a1, m_inst.rs1)));
         check_value("ALUop2", 64'(ALUop2), 64'(m_inst.src ? m_inst.imm : e2));
         check_value("out_rs2_fwd", 64'(out_rs2_fwd), 64'(e2));
         check_value("ALUctrl", 64'(ALUctrl), 64'(m_inst.ctrl));
         check_value("out_rd_addr", 64'(out_rd_addr), 64'(m_inst.rd));
         check_value("out_pc", 64'(out_pc), 64'(m_inst.pc));
         check_value("out_ctrl", 64'({out_reg_write, out_mem_read, out_branch}),
                     64'({m_inst.rw, m_inst.mr, m_inst.br}));
      end
      @(posedge clk);
      if (lu && m_bubbles < 65535) m_bubbles++;
      if (flush) begin
         m_valid = 1'b0;
      end else if (in_valid && ir) begin
         m_valid = 1'b1;
         m_inst  = '{rs1: in_rs1_data, rs2: in_rs2_data, imm: in_imm, pc: in_pc,
                     a1: in_rs1_addr, a2: in_rs2_addr, rd: in_rd_addr, src: in_alu_src,
                     ctrl: in_alu_ctrl, rw: in_reg_write, mr: in_mem_read, br: in_branch};
      end else if (ov && out_ready) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic set_inst(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] rd, input logic src, input logic [2:0] ctrl);
      in_valid = 1'b1; in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_pc = pc;
      in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd; in_alu_src = src;
      in_alu_ctrl = ctrl; in_reg_write = 1'b1; in_mem_read = 1'b0; in_branch = 1'b0;
   endtask

   task automatic quiet_hazards();
      mem_rd_addr = 5'd0; mem_reg_write = 1'b0; mem_is_load = 1'b0; mem_result = 32'd0;
      wb_rd_addr = 5'd0; wb_reg_write = 1'b0; wb_result = 32'd0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      set_inst(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000);
      in_valid = 1'b0; in_reg_write = 1'b0;
      quiet_hazards();
      model_reset();
      repeat (2) @(negedge clk);
      check_value("rst_out_valid", 64'(out_valid), 64'd0);
      check_value("rst_bubbles", 64'(bubble_count), 64'd0);
      rst_n = 1'b1;
      cycle();

      // Reset in the middle of a held instruction
      set_inst(32'd5, 32'd7, 32'd0, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 3'b000);
      cycle();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_value("midrst_valid", 64'(out_valid), 64'd0);
      check_value("midrst_op1", 64'(ALUop1), 64'd0);
      check_value("midrst_op2", 64'(ALUop2), 64'd0);
      check_value("midrst_pc", 64'(out_pc), 64'd0);
      check_value("midrst_rd", 64'(out_rd_addr), 64'd0);
      check_value("midrst_rw", 64'(out_reg_write), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Basic pass-through, register then immediate operand
      set_inst(32'd5, 32'd7, 32'd0, 32'h200, 5'd1, 5'd2, 5'd3, 1'b0, 3'b000);
      cycle();
      set_inst(32'd5, 32'd7, 32'hFFFF_FFFC, 32'h204, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000);
      #1;
      check_value("basic_op1", 64'(ALUop1), 64'd5);
      check_value("basic_op2", 64'(ALUop2), 64'd7);
      cycle();
      in_valid = 1'b0;
      #1 check_value("imm_op2", 64'(ALUop2), 64'hFFFF_FFFC);
      cycle();

      // Forwarding priority under backpressure
      set_inst(32'hAA, 32'hBB, 32'd0, 32'h300, 5'd3, 5'd6, 5'd7, 1'b0, 3'b010);
      cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'h11;
      wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_result = 32'h22;
      #1 check_value("fwd_mem_prio", 64'(ALUop1), C_FWD ? 64'h11 : 64'hAA);
      cycle();
      mem_reg_write = 1'b0;
      #1 check_value("fwd_wb", 64'(ALUop1), C_FWD ? 64'h22 : 64'hAA);
      cycle();
      out_ready = 1'b1;
      quiet_hazards();
      set_inst(32'h55, 32'h66, 32'd0, 32'h304, 5'd0, 5'd6, 5'd7, 1'b0, 3'b011);
      mem_reg_write = 1'b1; wb_reg_write = 1'b1;
      cycle();
      in_valid = 1'b0;
      #1 check_value("fwd_x0", 64'(ALUop1), 64'h55);
      cycle();
      quiet_hazards();

      // Load-use bubble then WB forwarding
      set_inst(32'h33, 32'h44, 32'd0, 32'h400, 5'd1, 5'd4, 5'd5, 1'b0, 3'b001);
      cycle();
      in_valid = 1'b0;
      mem_is_load = 1'b1; mem_reg_write = 1'b1; mem_rd_addr = 5'd4;
      #1;
      check_value("lu_out_valid", 64'(out_valid), C_FWD ? 64'd0 : 64'd1);
      check_value("lu_in_ready", 64'(in_ready), C_FWD ? 64'd0 : 64'd1);
      cycle();
      quiet_hazards();
      wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_result = 32'h99;
      #1;
      check_value("lu_bubbles", 64'(bubble_count), C_FWD ? 64'd1 : 64'd0);
      check_value("lu_resolve_valid", 64'(out_valid), C_FWD ? 64'd1 : 64'd0);
      check_value("lu_resolve_op2", 64'(ALUop2), C_FWD ? 64'h99 : 64'h44);
      cycle();
      quiet_hazards();

      // Backpressure then flush
      set_inst(32'h1234, 32'h5678, 32'd0, 32'h500, 5'd8, 5'd9, 5'd10, 1'b0, 3'b101);
      cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_value("bp_in_ready", 64'(in_ready), 64'd0);
         check_value("bp_op1", 64'(ALUop1), 64'h1234);
         check_value("bp_pc", 64'(out_pc), 64'h500);
         cycle();
      end
      set_inst(32'h1, 32'h2, 32'd0, 32'h600, 5'd11, 5'd12, 5'd13, 1'b0, 3'b000);
      flush = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check_value("flush_valid", 64'(out_valid), 64'd0);
      check_value("flush_rw", 64'(out_reg_write), 64'd0);
      cycle();

      // Randomized traffic with hazards on a narrow register range
      for (int n = 0; n < 3000; n++) begin
         in_valid      = ($urandom_range(0, 9) < 7);
         in_rs1_data   = $urandom;  in_rs2_data = $urandom;
         in_imm        = $urandom;  in_pc       = $urandom;
         in_rs1_addr   = 5'($urandom_range(0, 7));
         in_rs2_addr   = 5'($urandom_range(0, 7));
         in_rd_addr    = 5'($urandom_range(0, 31));
         in_alu_src    = 1'($urandom_range(0, 1));
         in_alu_ctrl   = 3'($urandom_range(0, 7));
         in_reg_write  = 1'($urandom_range(0, 1));
         in_mem_read   = 1'($urandom_range(0, 1));
         in_branch     = 1'($urandom_range(0, 1));
         flush         = ($urandom_range(0, 19) == 0);
         out_ready     = ($urandom_range(0, 3) != 0);
         mem_rd_addr   = 5'($urandom_range(0, 7));
         mem_reg_write = 1'($urandom_range(0, 1));
         mem_is_load   = ($urandom_range(0, 3) == 0);
         mem_result    = $urandom;
         wb_rd_addr    = 5'($urandom_range(0, 7));
         wb_reg_write  = 1'($urandom_range(0, 1));
         wb_result     = $urandom;
         cycle();
      end

      // Bubble counter saturation
      flush = 1'b0; out_ready = 1'b1;
      quiet_hazards();
      set_inst(32'h7, 32'h8, 32'd0, 32'h700, 5'd4, 5'd2, 5'd3, 1'b0, 3'b000);
      cycle();
      in_valid = 1'b0;
      mem_is_load = 1'b1; mem_reg_write = 1'b1; mem_rd_addr = 5'd4;
      repeat (65540) cycle();
      #1 check_value("bubble_sat", 64'(bubble_count), C_FWD ? 64'hFFFF : 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
